// File: rtl/osc_pkg.sv
// osc_pkg: shared prescaler state encoding, oscillator constants and divisor helper.
package osc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PEND} presc_state_t;

   localparam int unsigned OSC_HZ          = 5500000;
   localparam int unsigned DIV_DEFAULT_HZ2 = OSC_HZ / 2;

   function automatic logic [31:0] eff_period(input logic [31:0] n);
      return (n == '0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/osc_prescaler.sv
// osc_prescaler: divides clk_i into a one-cycle tick_o every P=max(N,1) cycles; divisor reloads land on tick boundaries.
// Define PRESCALER_SQW_EN to add sqw_o, a square wave toggling on every tick.
module osc_prescaler
   import osc_pkg::*;
#(
   parameter int unsigned DIV_W       = 24,
   parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_HZ2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             div_valid_i,
   input  logic [DIV_W-1:0] div_data_i,
   output logic             div_ready_o,
   output logic             tick_o,
`ifdef PRESCALER_SQW_EN
   output logic             sqw_o,
`endif
   output logic             running_o
);

   presc_state_t     state_q, state_d;
   logic [DIV_W-1:0] period_q, period_d, pending_q, pending_d, cnt_q, cnt_d;
   logic [DIV_W-1:0] cur_m1, new_m1, pend_m1, cnt_dec;
   logic             tick_q, tick_d, accept, wrap;

   assign div_ready_o = state_q != PEND;
   assign running_o   = state_q != IDLE;
   assign tick_o      = tick_q;
   assign accept      = div_valid_i && div_ready_o;
   assign wrap        = cnt_q == '0;
   assign cnt_dec     = cnt_q - DIV_W'(1);
   assign cur_m1      = DIV_W'(eff_period(32'(period_q)) - 32'd1);
   assign new_m1      = DIV_W'(eff_period(32'(div_data_i)) - 32'd1);
   assign pend_m1     = DIV_W'(eff_period(32'(pending_q)) - 32'd1);

   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      if (state_q == PEND) begin
         // Leaving PEND either way commits the pending divisor.
         if (!en_i || wrap) begin
            period_d = pending_q;
            cnt_d    = pend_m1;
            tick_d   = en_i;
            state_d  = en_i ? RUN : IDLE;
         end else
            cnt_d = cnt_dec;
      end else if (state_q == IDLE || !en_i) begin
         period_d = accept ? div_data_i : period_q;
         cnt_d    = accept ? new_m1 : cur_m1;
         state_d  = en_i ? RUN : IDLE;
      end else begin
         tick_d    = wrap;
         cnt_d     = wrap ? cur_m1 : cnt_dec;
         pending_d = accept ? div_data_i : pending_q;
         state_d   = accept ? PEND : RUN;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         period_q  <= DIV_W'(DIV_DEFAULT);
         pending_q <= '0;
         cnt_q     <= DIV_W'(eff_period(DIV_DEFAULT) - 32'd1);
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
      end
   end

`ifdef PRESCALER_SQW_EN
   logic sqw_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         sqw_q <= 1'b0;
      else
         sqw_q <= sqw_q ^ tick_d;
   end

   assign sqw_o = sqw_q;
`endif

endmodule

// File: tb/tb_osc_prescaler.sv
// tb_osc_prescaler: directed checks of tick spacing, divisor handshake, idle/run transitions and reset.
module tb_osc_prescaler;

   logic       clk = 1'b0, rst = 1'b0, en = 1'b0, div_valid = 1'b0;
   logic [7:0] div_data = 8'd0;
   logic       div_ready, tick, running;
`ifdef PRESCALER_SQW_EN
   logic       sqw;
`endif
   int         nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   osc_prescaler #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .en_i(en),
      .div_valid_i(div_valid),
      .div_data_i(div_data),
      .div_ready_o(div_ready),
      .tick_o(tick),
`ifdef PRESCALER_SQW_EN
      .sqw_o(sqw),
`endif
      .running_o(running)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic next_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < 50);
   endtask

   task automatic offer(input logic [7:0] d);
      div_valid = 1'b1;
      div_data  = d;
      step();
      div_valid = 1'b0;
      div_data  = 8'hAA;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #2 rst = 1'b1;
      #1;
      chk("rst_tick", tick, 0);
      chk("rst_running", running, 0);
      chk("rst_ready", div_ready, 1);
      step();
      step();
      rst = 1'b0;
      en = 1'b1;
      step();
      chk("e0_running", running, 1);
      chk("e0_tick", tick, 0);
      next_tick(n); chk("first_p4", n, 4);
      next_tick(n); chk("p4", n, 4);
      step();
      offer(8'd6);
      chk("pend_ready", div_ready, 0);
      next_tick(n); chk("straddle", n, 2);
      chk("ready_back", div_ready, 1);
      next_tick(n); chk("p6", n, 6);
      next_tick(n); chk("p6_b", n, 6);
      en = 1'b0;
      step();
      chk("idle_running", running, 0);
      chk("idle_tick", tick, 0);
      offer(8'd0);
      offer(8'd1);
      en = 1'b1;
      step();
      chk("p1_e0", tick, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("p1_tick", tick, 1);
      end
      en = 1'b0;
      step();
      chk("drop_on_tick", tick, 0);
      chk("drop_running", running, 0);
      offer(8'd3);
      en = 1'b1;
      step();
      next_tick(n); chk("p3", n, 3);
      step();
      step();
      div_valid = 1'b1;
      div_data  = 8'd5;
      step();
      div_valid = 1'b0;
      chk("wrap_accept_tick", tick, 1);
      chk("wrap_accept_ready", div_ready, 0);
      next_tick(n); chk("p3_old", n, 3);
      chk("wrap_ready_back", div_ready, 1);
      next_tick(n); chk("p5", n, 5);
      step();
      offer(8'd7);
      chk("pend7_ready", div_ready, 0);
      en = 1'b0;
      step();
      chk("pend_drop_running", running, 0);
      chk("pend_drop_ready", div_ready, 1);
      chk("pend_drop_tick", tick, 0);
      step();
      step();
      chk("still_idle", running, 0);
      en = 1'b1;
      step();
      next_tick(n); chk("p7", n, 7);
      next_tick(n); chk("p7_b", n, 7);
      step();
      offer(8'd9);
      chk("pend9_ready", div_ready, 0);
      step();
      rst = 1'b1;
      #2;
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_ready", div_ready, 1);
      chk("mid_rst_running", running, 0);
`ifdef PRESCALER_SQW_EN
      chk("mid_rst_sqw", sqw, 0);
`endif
      step();
      rst = 1'b0;
      step();
      next_tick(n); chk("rst_p4", n, 4);
`ifdef PRESCALER_SQW_EN
      chk("sqw_hi", sqw, 1);
`endif
      next_tick(n); chk("rst_p4_b", n, 4);
`ifdef PRESCALER_SQW_EN
      chk("sqw_lo", sqw, 0);
`endif
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/osc_prescaler.md
# osc_prescaler

Programmable clock-enable prescaler between the internal UFM oscillator (`altufm_osc`, ~5.5 MHz) and the LED blink counter. Divides the free-running `clk` into a one-cycle `tick` enable every N cycles. The downstream counter advances only on `tick`, so its blink rate is set at run time without a second clock domain. The divisor is reloaded through a valid/ready handshake and takes effect only on a tick boundary, so no period is ever shortened or torn.

## Interface
- `DIV_W`, 24: divisor width in bits.
- `DIV_DEFAULT`, 2750000: divisor after reset (≈0.5 s at 5.5 MHz).
- `clk`  in  1: oscillator clock; all logic on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: run request, level-sensitive, synchronous to `clk`.
- `div_valid`  in  1: new divisor offered.
- `div_data`  in  DIV_W: offered divisor N.
- `div_ready`  out  1: block can accept a divisor.
- `tick`  out  1: registered one-cycle enable pulse.
- `running`  out  1: high in RUN or PEND.

## Operation
- Registers:
  - `period` (DIV_W): active divisor.
  - `pending` (DIV_W): accepted, not yet applied.
  - `cnt` (DIV_W): down-counter.
  - `tick`.
  - FSM state.
- Effective period P = max(N,1). N=0 is treated as 1.
- FSM states:
  - IDLE: `cnt` held at P−1; `tick`=0.
    - `en`=1 → RUN.
    - Accepted divisor is written to `period` and `cnt` on the next edge, with no pending phase.
  - RUN, per edge:
    - If `cnt`==0: `cnt`<=P−1, `tick`<=1.
    - Else: `cnt`<=`cnt`−1, `tick`<=0.
    - `en`=0 → IDLE. `cnt` is reloaded to P−1, `tick`<=0.
    - Handshake accept → PEND; value goes to `pending`.
  - PEND: counts like RUN with the old `period`.
    - On the edge where `cnt`==0: `tick`<=1, `period`<=`pending`, `cnt`<=max(pending,1)−1, → RUN.
    - `en`=0 → IDLE; `pending` is applied to `period` immediately.
- Handshake rules:
  - Transfer happens when `div_valid` && `div_ready` at an edge.
  - `div_ready` = (state != PEND).
  - `div_data` is ignored without `div_valid`.
  - `div_valid` may be held; no combinational path from `div_valid` to `div_ready`.
- Simultaneous events:
  - Accept in RUN on the edge where `cnt`==0: the tick fires and reloads with the old P. The new value waits for the next boundary.
  - `en` falling on a tick edge: IDLE wins, and no tick is issued on that edge.
- Reset mid-operation: all state is cleared asynchronously; any pending divisor is discarded.

## Timing
- Reset values:
  - `tick`=0, `running`=0, `div_ready`=1.
  - `period`=DIV_DEFAULT, `cnt`=DIV_DEFAULT−1, `pending`=0.
  - State IDLE.
- Start: `en` is sampled high at edge E0. The first `tick` is asserted after edge E(P). After that, `tick` repeats exactly every P cycles for as long as `en` stays high.
- P=1: `tick` is high every cycle from E1 on.
- Divisor change latency: applied at the first tick boundary after acceptance. The period straddling the change keeps the old value.
- `tick` is always exactly one cycle wide, except when P=1.
- `running` tracks state with zero extra latency (decoded from the state register).

## Configuration
- `PRESCALER_SQW_EN`:
  - Defined: adds output `sqw` (1 bit, reset 0), which toggles on every edge where `tick`<=1. The result is a 50% square wave with period 2P, usable to drive an LED directly. `sqw` holds its value in IDLE.
  - Undefined: the port and its register are absent; behaviour is otherwise identical.

## Structure
- Shared package `osc_pkg`:
  - State enum `presc_state_t` (IDLE, RUN, PEND).
  - Constants `OSC_HZ` = 5500000 and `DIV_DEFAULT_HZ2` = OSC_HZ/2.
  - Function `eff_period(N)` returning max(N,1).
- Single module; no sub-module is needed. The down-counter stays inline because its reload mux depends on FSM state.

## Test plan
- Reset with `DIV_DEFAULT`=4, then `en`=1 → first `tick` 4 cycles after `en` is sampled; pulses every 4 cycles; `running`=1.
- In RUN with P=4, offer N=6 mid-period → `div_ready` drops for the rest of that period. The next interval is 4, the following ones are 6, and `div_ready` returns high with that tick.
- Offer N=0 and then N=1 while in IDLE, then `en`=1 → `tick` high every cycle from E1; no X, no stall.
- Accept the divisor exactly on the `cnt`==0 edge (P=3, N=5) → tick on that edge, next interval 3, then 5.
- Drop `en` in PEND (pending N=7), then re-raise `en` → first tick after 7 cycles; `running`=0 while idle.
- Assert `rst` mid-count with a pending divisor → `tick`=0, `div_ready`=1, and the period reverts to `DIV_DEFAULT`. With `PRESCALER_SQW_EN`, `sqw`=0 and toggles every P cycles after restart.
